// File: rtl/keypad_scan_if.sv
// Keypad scanner bundle: keypad row/column lines plus the decoded key report.
// Ports: row (keypad -> scanner), col (scanner -> keypad),
//        key_valid / key_code / key_down (scanner -> game logic).
interface keypad_scan_if;
  logic [3:0] row;        // row lines, pulled up, 0 = pressed
  logic [3:0] col;        // one-hot active-low column drive
  logic       key_valid;  // one-cycle pulse per clean single-key press
  logic [3:0] key_code;   // {row_idx, col_idx} of the last reported key
  logic       key_down;   // stable snapshot has at least one key pressed

  // Scanner side.
  modport master (
    input  row,
    output col,
    output key_valid,
    output key_code,
    output key_down
  );

  // Keypad / consumer side.
  modport slave (
    output row,
    input  col,
    input  key_valid,
    input  key_code,
    input  key_down
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column multiplex, frame debounce, single-key report FSM.
// Ports: clk, rst (sync, active-high), kp (keypad_scan_if.master: row in;
//        col, key_valid, key_code, key_down out). No backpressure: key_valid is a pulse.
module keypad_scan #(
  parameter int SCAN_DIV = 100000,  // clk cycles per column slot, >= 4
  parameter int DEBOUNCE = 4        // identical frames before a snapshot is stable, >= 1
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchronizer. Reset to "nothing pressed" so no phantom key appears.
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot divider: tick on the last cycle of each column slot.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Column scan. The column register moves on the tick, so the new column
  // is driven for the whole following slot and rows settle before sampling.
  // ---------------------------------------------------------------------------
  logic [1:0] col_idx;
  logic [1:0] col_idx_nxt;
  logic [3:0] col_reg;
  logic       frame_end;

  assign col_idx_nxt = col_idx + 2'd1;
  assign frame_end   = tick && (col_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx <= 2'd0;
      col_reg <= 4'b1110;
    end else if (tick) begin
      col_idx <= col_idx_nxt;
      col_reg <= ~(4'b0001 << col_idx_nxt);
    end
  end

  // ---------------------------------------------------------------------------
  // Raw frame assembly. raw_next already contains the column being sampled
  // this tick, so the frame-end tick sees the complete 16-bit frame.
  // Bit index = row*4 + col.
  // ---------------------------------------------------------------------------
  logic [15:0] raw;
  logic [15:0] raw_next;

  always_comb begin
    raw_next = raw;
    for (int c = 0; c < 4; c++) begin
      if (col_idx == 2'(c)) begin
        for (int r = 0; r < 4; r++) begin
          raw_next[r*4 + c] = ~row_sync[r];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw <= '0;
    end else if (tick) begin
      raw <= raw_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame debounce. A frame that differs from the candidate restarts the
  // count at 1; with DEBOUNCE = 1 that alone makes it stable.
  // ---------------------------------------------------------------------------
  logic [15:0]      cand;
  logic [15:0]      cand_next;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_cnt_next;
  logic [15:0]      stable;
  logic [15:0]      stable_next;
  logic             stable_upd;

  always_comb begin
    cand_next   = cand;
    db_cnt_next = db_cnt;
    if (frame_end) begin
      if (raw_next != cand) begin
        cand_next   = raw_next;
        db_cnt_next = CNT_ONE;
      end else if (db_cnt < DB_TARGET) begin
        db_cnt_next = db_cnt + 1'b1;
      end
    end
  end

  assign stable_upd  = frame_end && (db_cnt_next == DB_TARGET);
  assign stable_next = stable_upd ? cand_next : stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= '0;
      db_cnt <= '0;
      stable <= '0;
    end else begin
      cand   <= cand_next;
      db_cnt <= db_cnt_next;
      stable <= stable_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Report FSM. Re-evaluating the same stable value on later frames is
  // harmless: PRESSED holds while the snapshot is still exactly its own key,
  // so a held key never pulses twice.
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic       key_valid_reg;
  logic       key_valid_nxt;
  logic [3:0] key_code_reg;
  logic [3:0] key_code_nxt;
  logic       key_down_reg;
  logic       key_down_nxt;

  logic       snap_zero;
  logic       snap_one_hot;
  logic       snap_same_key;
  logic [3:0] snap_idx;

  always_comb begin
    snap_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (stable_next[i]) begin
        snap_idx = 4'(i);
      end
    end
  end

  assign snap_zero     = (stable_next == 16'd0);
  // A power of two has no bits in common with itself minus one.
  assign snap_one_hot  = !snap_zero && ((stable_next & (stable_next - 16'd1)) == 16'd0);
  assign snap_same_key = (stable_next == (16'd1 << key_code_reg));

  always_comb begin
    state_nxt     = state;
    key_valid_nxt = 1'b0;
    key_code_nxt  = key_code_reg;
    key_down_nxt  = key_down_reg;
    if (stable_upd) begin
      key_down_nxt = !snap_zero;
      case (state)
        IDLE: begin
          if (snap_one_hot) begin
            state_nxt     = PRESSED;
            key_valid_nxt = 1'b1;
            key_code_nxt  = snap_idx;
          end else if (!snap_zero) begin
            state_nxt = LOCKED;
          end
        end
        PRESSED: begin
          if (snap_zero) begin
            state_nxt = IDLE;
          end else if (!snap_same_key) begin
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (snap_zero) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'd0;
      key_down_reg  <= 1'b0;
    end else begin
      state         <= state_nxt;
      key_valid_reg <= key_valid_nxt;
      key_code_reg  <= key_code_nxt;
      key_down_reg  <= key_down_nxt;
    end
  end

  assign kp.col       = col_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_code  = key_code_reg;
  assign kp.key_down  = key_down_reg;

endmodule
